ddr_cmd_decoder: RTL

// DIMM-side receiver for the DDR4 command/address bus. It samples the pin-level

---
 rtl/ddr_pkg.sv | 34 +++
 rtl/ddr_mr_capture.sv | 48 ++++
 rtl/ddr_cmd_decoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR4 command/address receiver.
//   cmd_t / command_type : decoded command
//   err_t                : protocol violation codes, lowest code = highest priority
//   MRx_IDX              : mode-register index {bg[0], ba}
//   DEF_*                : mode-register reset values
package ddr_pkg;

  typedef enum logic [3:0] {
    DES, NOP, ACT, MRS, REF, PRE, PREA, WR, WRA, RD, RDA, ZQCL
  } cmd_t;

  typedef cmd_t command_type;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_ILLEGAL, ERR_ACT_OPEN, ERR_CAS_CLOSED, ERR_BANK_OPEN, ERR_TRCD
  } err_t;

  localparam logic [2:0] MR0_IDX = 3'd0;
  localparam logic [2:0] MR1_IDX = 3'd1;
  localparam logic [2:0] MR2_IDX = 3'd2;
  localparam logic [2:0] MR6_IDX = 3'd6;

  localparam logic [4:0] DEF_CL   = 5'd9;
  localparam logic [4:0] DEF_AL   = 5'd0;
  localparam logic [4:0] DEF_CWL  = 5'd9;
  localparam logic [3:0] DEF_BL   = 4'd8;
  localparam logic [3:0] BL_CHOP  = 4'd4;
  localparam logic [3:0] DEF_TCCD = 4'd4;

  function automatic logic is_cas(input cmd_t c);
    return (c == WR) || (c == WRA) || (c == RD) || (c == RDA);
  endfunction

endpackage

// File: rtl/ddr_mr_capture.sv
// Mode-register capture: turns a registered MRS (index + opcode) into the
// latency / burst settings one cycle after the decoded MRS appears.
//   clk, rst_n : clock, async active-low reset
//   mrs_stb    : registered MRS strobe
//   mr_idx     : {bg[0], ba} of the MRS
//   op         : {A13..A0} of the MRS
//   cl, al, cwl, bl, tccd : current settings
module ddr_mr_capture
  import ddr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mrs_stb,
  input  logic [2:0]  mr_idx,
  input  logic [13:0] op,
  output logic [4:0]  cl,
  output logic [4:0]  al,
  output logic [4:0]  cwl,
  output logic [3:0]  bl,
  output logic [3:0]  tccd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl   <= DEF_CL;
      al   <= DEF_AL;
      cwl  <= DEF_CWL;
      bl   <= DEF_BL;
      tccd <= DEF_TCCD;
    end else if (mrs_stb) begin
      case (mr_idx)
        MR0_IDX: begin
          cl <= (op[6:3] < 4'd4) ? DEF_CL + 5'(op[6:3]) : DEF_CL;
          bl <= (op[1:0] == 2'b10) ? BL_CHOP : DEF_BL;
        end
        // AL is expressed relative to the CL in force when MR1 is written.
        MR1_IDX: al <= (op[4:3] == 2'd1 || op[4:3] == 2'd2) ? cl - 5'(op[4:3]) : '0;
        MR2_IDX: cwl <= (op[5:3] == 3'd0 || op[5:3] == 3'd2) ? DEF_CWL + 5'(op[5:3]) : DEF_CWL;
        MR6_IDX: tccd <= DEF_TCCD + 4'(op[12:10]);
        default: ;
      endcase
    end
  end

  logic unused_op;
  assign unused_op = ^{op[13], op[9:7], op[2]};

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR4 DIMM-side command/address receiver.
// Samples the pin command on posedge CK_c, registers the decoded command and
// fields (latency 1), tracks per-bank open state and open row, captures MRS
// settings and flags protocol violations.
//   CK_c, reset_n             : clock, async active-low reset
//   cs_n, act_n, RAS/CAS/WE   : command pins (RAS/CAS/WE double as A16..A14)
//   bg_addr, ba_addr, A*      : bank and address pins
//   dec_cmd, cmd_valid        : decoded command, pulse for non-DES/NOP
//   dec_bg/ba/row/col/bc_n    : decoded fields
//   bank_open                 : per-bank open flags
//   cl, al, cwl, bl, tccd     : mode-register settings
//   err_valid, err_code       : violation pulse and code
// Build option: define DDR_TRCD_CHECK_EN to build per-bank ACT-to-CAS
// counters and report ERR_TRCD.
module ddr_cmd_decoder
  import ddr_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned ROW_W     = 14,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned TRCD      = 11
) (
  input  logic                 CK_c,
  input  logic                 reset_n,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic                 RAS_n_A16,
  input  logic                 CAS_n_A15,
  input  logic                 WE_n_A14,
  input  logic [1:0]           bg_addr,
  input  logic [1:0]           ba_addr,
  input  logic                 A17,
  input  logic                 A13,
  input  logic                 A12_BC_n,
  input  logic                 A11,
  input  logic                 A10_AP,
  input  logic [9:0]           A9_A0,
  output cmd_t                 dec_cmd,
  output logic                 cmd_valid,
  output logic [1:0]           dec_bg,
  output logic [1:0]           dec_ba,
  output logic [ROW_W-1:0]     dec_row,
  output logic [COL_W-1:0]     dec_col,
  output logic                 dec_bc_n,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [4:0]           cl,
  output logic [4:0]           al,
  output logic [4:0]           cwl,
  output logic [3:0]           bl,
  output logic [3:0]           tccd,
  output logic                 err_valid,
  output err_t                 err_code
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);

  logic [BANK_W-1:0]               bank_idx;
  logic [13:0]                     addr_op;
  cmd_t                            cmd_nxt;
  err_t                            err_nxt;
  logic                            illegal;
  logic                            trcd_busy;
  logic [NUM_BANKS-1:0]            bank_open_nxt;
  logic [NUM_BANKS-1:0][ROW_W-1:0] open_row;

  assign bank_idx = BANK_W'({bg_addr, ba_addr});
  assign addr_op  = {A13, A12_BC_n, A11, A10_AP, A9_A0};

  always_comb begin
    cmd_nxt = DES;
    illegal = 1'b0;
    if (cs_n) begin
      cmd_nxt = DES;
    end else if (!act_n) begin
      cmd_nxt = ACT;
    end else begin
      case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
        3'b000:  cmd_nxt = MRS;
        3'b001:  cmd_nxt = REF;
        3'b010:  cmd_nxt = A10_AP ? PREA : PRE;
        3'b100:  cmd_nxt = A10_AP ? WRA : WR;
        3'b101:  cmd_nxt = A10_AP ? RDA : RD;
        3'b110: begin
          cmd_nxt = A10_AP ? ZQCL : NOP;
          illegal = !A10_AP;
        end
        3'b011: begin
          cmd_nxt = NOP;
          illegal = 1'b1;
        end
        default: cmd_nxt = NOP;
      endcase
    end
  end

  always_comb begin
    err_nxt = ERR_NONE;
    if (illegal)
      err_nxt = ERR_ILLEGAL;
    else if (cmd_nxt == ACT && bank_open[bank_idx])
      err_nxt = ERR_ACT_OPEN;
    else if (is_cas(cmd_nxt) && !bank_open[bank_idx])
      err_nxt = ERR_CAS_CLOSED;
    else if ((cmd_nxt == MRS || cmd_nxt == REF || cmd_nxt == ZQCL) && (|bank_open))
      err_nxt = ERR_BANK_OPEN;
    else if (is_cas(cmd_nxt) && trcd_busy)
      err_nxt = ERR_TRCD;
  end

  // Auto-precharge closes on the CAS edge; on a closed bank the clear is a no-op.
  always_comb begin
    bank_open_nxt = bank_open;
    case (cmd_nxt)
      ACT:          bank_open_nxt[bank_idx] = 1'b1;
      PRE, WRA, RDA: bank_open_nxt[bank_idx] = 1'b0;
      PREA:         bank_open_nxt = '0;
      default: ;
    endcase
  end

  always_ff @(posedge CK_c or negedge reset_n) begin
    if (!reset_n) begin
      dec_cmd   <= DES;
      cmd_valid <= 1'b0;
      dec_bg    <= '0;
      dec_ba    <= '0;
      dec_row   <= '0;
      dec_col   <= '0;
      dec_bc_n  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      bank_open <= '0;
      open_row  <= '0;
    end else begin
      dec_cmd   <= cmd_nxt;
      cmd_valid <= (cmd_nxt != DES) && (cmd_nxt != NOP);
      dec_bg    <= bg_addr;
      dec_ba    <= ba_addr;
      dec_row   <= ROW_W'(addr_op);
      dec_col   <= COL_W'(A9_A0);
      dec_bc_n  <= A12_BC_n;
      err_valid <= (err_nxt != ERR_NONE);
      err_code  <= err_nxt;
      bank_open <= bank_open_nxt;
      if (cmd_nxt == ACT)
        open_row[bank_idx] <= ROW_W'(addr_op);
    end
  end

`ifdef DDR_TRCD_CHECK_EN
  localparam int unsigned CNT_W = $clog2(TRCD + 1);

  logic [NUM_BANKS-1:0][CNT_W-1:0] trcd_cnt;

  always_ff @(posedge CK_c or negedge reset_n) begin
    if (!reset_n) begin
      trcd_cnt <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (cmd_nxt == ACT && bank_idx == BANK_W'(b))
          trcd_cnt[b] <= CNT_W'(TRCD - 1);
        else if (trcd_cnt[b] != '0)
          trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
      end
    end
  end

  assign trcd_busy = (trcd_cnt[bank_idx] != '0);
`else
  assign trcd_busy = 1'b0;

  logic unused_trcd;
  assign unused_trcd = ^TRCD;
`endif

  // MR settings follow the registered MRS, so they land one cycle after dec_cmd
  // and a reset between the two discards the update.
  ddr_mr_capture u_mr_capture (
    .clk     (CK_c),
    .rst_n   (reset_n),
    .mrs_stb (cmd_valid && dec_cmd == MRS),
    .mr_idx  ({dec_bg[0], dec_ba}),
    .op      (14'(dec_row)),
    .cl      (cl),
    .al      (al),
    .cwl     (cwl),
    .bl      (bl),
    .tccd    (tccd)
  );

  // The open-row table has no pin; it is kept for monitor visibility.
  logic unused_ok;
  assign unused_ok = ^{A17, open_row};

endmodule
